// File: rtl/t5_wbarb_if.sv
// Bundle of the N-master and single-slave Wishbone signals around t5_wbarb.
// The arbiter takes the master modport; the surrounding fabric takes the slave modport.
interface t5_wbarb_if #(
  parameter int XLEN = 32,
  parameter int NM   = 2
);
  localparam int SW = XLEN / 8;

  logic [NM*30-1:0]   m_adr;
  logic [NM*XLEN-1:0] m_dto;
  logic [NM*SW-1:0]   m_sel;
  logic [NM-1:0]      m_wre;
  logic [NM-1:0]      m_stb;
  logic [NM-1:0]      m_ack;
  logic [NM-1:0]      m_err;
  logic [XLEN-1:0]    m_dti;

  logic [29:0]        s_adr;
  logic [XLEN-1:0]    s_dto;
  logic [SW-1:0]      s_sel;
  logic               s_wre;
  logic               s_stb;
  logic               s_ack;
  logic [XLEN-1:0]    s_dti;

  modport master (
    input  m_adr, m_dto, m_sel, m_wre, m_stb, s_ack, s_dti,
    output m_ack, m_err, m_dti, s_adr, s_dto, s_sel, s_wre, s_stb
  );

  modport slave (
    output m_adr, m_dto, m_sel, m_wre, m_stb, s_ack, s_dti,
    input  m_ack, m_err, m_dti, s_adr, s_dto, s_sel, s_wre, s_stb
  );
endinterface

// File: rtl/t5_wbarb.sv
// Round-robin NM-to-1 Wishbone arbiter: registered grant (1 cycle request->s_stb), one idle cycle after each transfer.
// The slave stalls by withholding s_ack; an optional timeout releases the bus and pulses m_err to the stalled master.
module t5_wbarb #(
  parameter int XLEN = 32,
  parameter int NM   = 2,
  parameter int TMO  = 255
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  t5_wbarb_if.master    bus
);

  localparam int SW   = XLEN / 8;
  localparam int PW   = $clog2(NM);
  localparam int TLIM = (TMO > 0) ? TMO - 1 : 0;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [NM-1:0]   gnt, gnt_nxt;
  logic [NM-1:0]   err_q, err_nxt;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic [7:0]      tcnt, tcnt_nxt;

  logic [PW-1:0]   gidx;
  logic [PW-1:0]   gidx_inc;
  logic [PW-1:0]   pick_idx;
  logic            pick_vld;

  logic [29:0]     s_adr_mux;
  logic [XLEN-1:0] s_dto_mux;
  logic [SW-1:0]   s_sel_mux;
  logic            s_wre_mux;
  logic            s_stb_int;
  logic            ack_hit;
  logic            abort;
  logic            tmo_hit;

  // Binary index of the current grant; gnt is one-hot or zero.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NM; i++) begin
      if (gnt[i]) gidx = PW'(i);
    end
  end

  assign gidx_inc = (gidx == PW'(NM - 1)) ? '0 : gidx + 1'b1;

  // First requester at or above ptr, wrapping from NM-1 back to 0.
  always_comb begin
    logic [PW:0] cand;
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 0; k < NM; k++) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(NM)) cand = cand - (PW+1)'(NM);
      if (!pick_vld && bus.m_stb[cand[PW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[PW-1:0];
      end
    end
  end

  // AND-OR mux: with no grant every slave-side field reads as zero.
  always_comb begin
    s_adr_mux = '0;
    s_dto_mux = '0;
    s_sel_mux = '0;
    s_wre_mux = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (gnt[i]) begin
        s_adr_mux = s_adr_mux | bus.m_adr[i*30 +: 30];
        s_dto_mux = s_dto_mux | bus.m_dto[i*XLEN +: XLEN];
        s_sel_mux = s_sel_mux | bus.m_sel[i*SW +: SW];
        s_wre_mux = s_wre_mux | bus.m_wre[i];
      end
    end
  end

  assign s_stb_int = |(gnt & bus.m_stb);
  assign ack_hit   = bus.s_ack & s_stb_int;
  assign abort     = (state == GRANT) & ~s_stb_int;
  assign tmo_hit   = (TMO != 0) && s_stb_int && !bus.s_ack && (tcnt == 8'(TLIM));

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    ptr_nxt   = ptr;
    tcnt_nxt  = tcnt;
    err_nxt   = '0;
    unique case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt         = GRANT;
          gnt_nxt           = '0;
          gnt_nxt[pick_idx] = 1'b1;
          tcnt_nxt          = '0;
        end
      end
      GRANT: begin
        // Ack beats a coinciding timeout; a dropped strobe ends the grant silently.
        if (ack_hit || abort || tmo_hit) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          ptr_nxt   = gidx_inc;
          tcnt_nxt  = '0;
          if (tmo_hit) err_nxt = gnt;
        end else begin
          tcnt_nxt = tcnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
      tcnt  <= '0;
      err_q <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      ptr   <= ptr_nxt;
      tcnt  <= tcnt_nxt;
      err_q <= err_nxt;
    end
  end

  assign bus.s_adr = s_adr_mux;
  assign bus.s_dto = s_dto_mux;
  assign bus.s_sel = s_sel_mux;
  assign bus.s_wre = s_wre_mux;
  assign bus.s_stb = s_stb_int;
  assign bus.m_ack = gnt & {NM{ack_hit}};
  assign bus.m_err = err_q;
  assign bus.m_dti = bus.s_dti;

endmodule

// File: tb/tb_t5_wbarb.sv
// Directed bench for t5_wbarb: a 2-master instance (TMO=4) and a 4-master instance (TMO=255).
module tb_t5_wbarb;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  t5_wbarb_if #(.XLEN(32), .NM(2)) b2 ();
  t5_wbarb_if #(.XLEN(32), .NM(4)) b4 ();

  t5_wbarb #(.XLEN(32), .NM(2), .TMO(4))   dut2 (.sys_clk(clk), .sys_rst(rst), .bus(b2));
  t5_wbarb #(.XLEN(32), .NM(4), .TMO(255)) dut4 (.sys_clk(clk), .sys_rst(rst), .bus(b4));

  task automatic idle_inputs();
    b2.m_adr = '0; b2.m_dto = '0; b2.m_sel = '0; b2.m_wre = '0; b2.m_stb = '0;
    b2.s_ack = 1'b0; b2.s_dti = '0;
    b4.m_adr = '0; b4.m_dto = '0; b4.m_sel = '0; b4.m_wre = '0; b4.m_stb = '0;
    b4.s_ack = 1'b0; b4.s_dti = '0;
  endtask

  // Leaves the caller at posedge+1 with reset released.
  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    b2.m_stb = 2'b11; b2.m_adr = {30'h3AA, 30'h155}; b2.m_wre = 2'b11; b2.m_sel = 8'hFF;
    b2.s_ack = 1'b1; b2.s_dti = 32'h12345678;
    b4.m_stb = 4'hF; b4.s_ack = 1'b1;
    step();
    vectors++; if (b2.s_stb !== 1'b0)    begin miscompares++; $display("FAIL reset_s_stb: got %b want 0", b2.s_stb); end
    vectors++; if (b2.s_adr !== 30'h0)   begin miscompares++; $display("FAIL reset_s_adr: got %h want 0", b2.s_adr); end
    vectors++; if (b2.s_wre !== 1'b0)    begin miscompares++; $display("FAIL reset_s_wre: got %b want 0", b2.s_wre); end
    vectors++; if (b2.s_sel !== 4'h0)    begin miscompares++; $display("FAIL reset_s_sel: got %h want 0", b2.s_sel); end
    vectors++; if (b2.s_dto !== 32'h0)   begin miscompares++; $display("FAIL reset_s_dto: got %h want 0", b2.s_dto); end
    vectors++; if (b2.m_ack !== 2'b00)   begin miscompares++; $display("FAIL reset_m_ack: got %b want 00", b2.m_ack); end
    vectors++; if (b2.m_err !== 2'b00)   begin miscompares++; $display("FAIL reset_m_err: got %b want 00", b2.m_err); end
    vectors++; if (b2.m_dti !== 32'h12345678) begin miscompares++; $display("FAIL reset_m_dti: got %h want 12345678", b2.m_dti); end
    vectors++; if (b4.s_stb !== 1'b0)    begin miscompares++; $display("FAIL reset4_s_stb: got %b want 0", b4.s_stb); end
    vectors++; if (b4.m_ack !== 4'h0)    begin miscompares++; $display("FAIL reset4_m_ack: got %b want 0000", b4.m_ack); end
  endtask

  task automatic test_single_read();
    do_reset();
    b2.m_adr = {30'h0, 30'h100}; b2.m_sel = 8'h0F; b2.m_stb = 2'b01;
    @(negedge clk);
    vectors++; if (b2.s_stb !== 1'b0) begin miscompares++; $display("FAIL single_latency: s_stb got %b want 0", b2.s_stb); end
    step(); @(negedge clk);
    vectors++; if (b2.s_stb !== 1'b1)   begin miscompares++; $display("FAIL single_stb: got %b want 1", b2.s_stb); end
    vectors++; if (b2.s_adr !== 30'h100) begin miscompares++; $display("FAIL single_adr: got %h want 100", b2.s_adr); end
    vectors++; if (b2.m_ack !== 2'b00)  begin miscompares++; $display("FAIL single_noack: got %b want 00", b2.m_ack); end
    step(); b2.s_ack = 1'b1; b2.s_dti = 32'hDEADBEEF;
    @(negedge clk);
    vectors++; if (b2.m_ack !== 2'b01)  begin miscompares++; $display("FAIL single_ack: got %b want 01", b2.m_ack); end
    vectors++; if (b2.m_dti !== 32'hDEADBEEF) begin miscompares++; $display("FAIL single_dti: got %h want deadbeef", b2.m_dti); end
    step(); b2.m_stb = 2'b00; b2.s_ack = 1'b0;
    @(negedge clk);
    vectors++; if (b2.s_stb !== 1'b0)   begin miscompares++; $display("FAIL single_release: s_stb got %b want 0", b2.s_stb); end
    // ptr advanced to 1, so master 1 wins a simultaneous request.
    b2.m_adr = {30'h200, 30'h100}; b2.m_stb = 2'b11;
    step(); @(negedge clk);
    vectors++; if (b2.s_adr !== 30'h200) begin miscompares++; $display("FAIL single_ptr: s_adr got %h want 200", b2.s_adr); end
    b2.m_stb = 2'b00;
  endtask

  task automatic test_alternate();
    logic [1:0]  exp_ack [8] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    logic [29:0] exp_adr [8] = '{30'h0, 30'h100, 30'h0, 30'h200, 30'h0, 30'h100, 30'h0, 30'h200};
    do_reset();
    b2.m_adr = {30'h200, 30'h100}; b2.m_stb = 2'b11; b2.s_ack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      vectors++; if (b2.m_ack !== exp_ack[k]) begin miscompares++; $display("FAIL alt_ack[%0d]: got %b want %b", k, b2.m_ack, exp_ack[k]); end
      vectors++; if (b2.s_adr !== exp_adr[k]) begin miscompares++; $display("FAIL alt_adr[%0d]: got %h want %h", k, b2.s_adr, exp_adr[k]); end
      vectors++; if (b2.s_stb !== k[0])       begin miscompares++; $display("FAIL alt_stb[%0d]: got %b want %b", k, b2.s_stb, k[0]); end
      step();
    end
    b2.m_stb = 2'b00; b2.s_ack = 1'b0;
  endtask

  task automatic test_fair4();
    logic [3:0]  exp_ack [8] = '{4'b0000, 4'b1000, 4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0010};
    logic [29:0] exp_adr [8] = '{30'h0, 30'h13, 30'h0, 30'h11, 30'h0, 30'h13, 30'h0, 30'h11};
    do_reset();
    b4.m_adr = {30'h13, 30'h12, 30'h11, 30'h10}; b4.m_stb = 4'b0010; b4.s_ack = 1'b1;
    step(); @(negedge clk);
    vectors++; if (b4.m_ack !== 4'b0010) begin miscompares++; $display("FAIL fair_setup: m_ack got %b want 0010", b4.m_ack); end
    // ptr now 2; masters 1 and 3 request continuously.
    step(); b4.m_stb = 4'b1010;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      vectors++; if (b4.m_ack !== exp_ack[k]) begin miscompares++; $display("FAIL fair_ack[%0d]: got %b want %b", k, b4.m_ack, exp_ack[k]); end
      vectors++; if (b4.s_adr !== exp_adr[k]) begin miscompares++; $display("FAIL fair_adr[%0d]: got %h want %h", k, b4.s_adr, exp_adr[k]); end
      step();
    end
    b4.m_stb = 4'b0000; b4.s_ack = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    b2.m_adr = {30'h55, 30'h66}; b2.m_dto = {32'hCAFEF00D, 32'h0}; b2.m_sel = 8'hF0;
    b2.m_wre = 2'b10; b2.m_stb = 2'b10;
    @(negedge clk);
    vectors++; if (b2.s_stb !== 1'b0) begin miscompares++; $display("FAIL tmo_c0_stb: got %b want 0", b2.s_stb); end
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 2) b2.m_stb = 2'b11;
      @(negedge clk);
      vectors++; if (b2.s_stb !== 1'b1)  begin miscompares++; $display("FAIL tmo_stb[%0d]: got %b want 1", k, b2.s_stb); end
      vectors++; if (b2.s_adr !== 30'h55) begin miscompares++; $display("FAIL tmo_adr[%0d]: got %h want 55", k, b2.s_adr); end
      vectors++; if (b2.s_wre !== 1'b1 || b2.s_sel !== 4'hF || b2.s_dto !== 32'hCAFEF00D) begin
        miscompares++; $display("FAIL tmo_wr[%0d]: got wre=%b sel=%h dto=%h want 1 f cafef00d", k, b2.s_wre, b2.s_sel, b2.s_dto); end
      vectors++; if (b2.m_err !== 2'b00 || b2.m_ack !== 2'b00) begin
        miscompares++; $display("FAIL tmo_quiet[%0d]: got err=%b ack=%b want 00 00", k, b2.m_err, b2.m_ack); end
    end
    step(); @(negedge clk);
    vectors++; if (b2.m_err !== 2'b10) begin miscompares++; $display("FAIL tmo_err: got %b want 10", b2.m_err); end
    vectors++; if (b2.s_stb !== 1'b0 || b2.m_ack !== 2'b00) begin
      miscompares++; $display("FAIL tmo_release: got stb=%b ack=%b want 0 00", b2.s_stb, b2.m_ack); end
    step(); @(negedge clk);
    vectors++; if (b2.m_err !== 2'b00) begin miscompares++; $display("FAIL tmo_err_pulse: got %b want 00", b2.m_err); end
    vectors++; if (b2.s_stb !== 1'b1 || b2.s_adr !== 30'h66 || b2.s_wre !== 1'b0) begin
      miscompares++; $display("FAIL tmo_next: got stb=%b adr=%h wre=%b want 1 66 0", b2.s_stb, b2.s_adr, b2.s_wre); end
    b2.m_stb = 2'b00; b2.m_wre = 2'b00;
  endtask

  task automatic test_tmo_ack();
    do_reset();
    b2.m_adr = {30'h0, 30'h77}; b2.m_stb = 2'b01;
    for (int k = 1; k <= 3; k++) step();
    step(); b2.s_ack = 1'b1;
    @(negedge clk);
    vectors++; if (b2.m_ack !== 2'b01) begin miscompares++; $display("FAIL tmoack_ack: got %b want 01", b2.m_ack); end
    step(); b2.s_ack = 1'b0; b2.m_stb = 2'b00;
    @(negedge clk);
    vectors++; if (b2.m_err !== 2'b00) begin miscompares++; $display("FAIL tmoack_err: got %b want 00", b2.m_err); end
  endtask

  task automatic test_abort();
    do_reset();
    b2.m_adr = {30'h200, 30'h100}; b2.m_stb = 2'b01;
    step(); @(negedge clk);
    vectors++; if (b2.s_stb !== 1'b1) begin miscompares++; $display("FAIL abort_grant: s_stb got %b want 1", b2.s_stb); end
    step(); b2.m_stb = 2'b00; b2.s_ack = 1'b1;
    @(negedge clk);
    vectors++; if (b2.m_ack !== 2'b00) begin miscompares++; $display("FAIL abort_ack: got %b want 00", b2.m_ack); end
    vectors++; if (b2.s_stb !== 1'b0)  begin miscompares++; $display("FAIL abort_stb: got %b want 0", b2.s_stb); end
    step(); b2.s_ack = 1'b0; b2.m_stb = 2'b11;
    @(negedge clk);
    vectors++; if (b2.s_stb !== 1'b0 || b2.m_err !== 2'b00) begin
      miscompares++; $display("FAIL abort_idle: got stb=%b err=%b want 0 00", b2.s_stb, b2.m_err); end
    step(); @(negedge clk);
    vectors++; if (b2.s_adr !== 30'h200 || b2.s_stb !== 1'b1) begin
      miscompares++; $display("FAIL abort_ptr: got adr=%h stb=%b want 200 1", b2.s_adr, b2.s_stb); end
    b2.m_stb = 2'b00;
  endtask

  task automatic test_reset_mid();
    do_reset();
    b2.m_adr = {30'h200, 30'h100}; b2.m_stb = 2'b01; b2.s_ack = 1'b1;
    step(); @(negedge clk);
    vectors++; if (b2.m_ack !== 2'b01) begin miscompares++; $display("FAIL rmid_first: m_ack got %b want 01", b2.m_ack); end
    step(); b2.m_stb = 2'b10; b2.s_ack = 1'b0;
    step();
    vectors++; if (b2.s_stb !== 1'b1 || b2.s_adr !== 30'h200) begin
      miscompares++; $display("FAIL rmid_grant: got stb=%b adr=%h want 1 200", b2.s_stb, b2.s_adr); end
    b2.s_ack = 1'b1;
    #1;
    vectors++; if (b2.m_ack !== 2'b10) begin miscompares++; $display("FAIL rmid_pass: m_ack got %b want 10", b2.m_ack); end
    #1 rst = 1'b1;
    #1;
    vectors++; if (b2.s_stb !== 1'b0 || b2.s_adr !== 30'h0) begin
      miscompares++; $display("FAIL rmid_stb: got stb=%b adr=%h want 0 0", b2.s_stb, b2.s_adr); end
    vectors++; if (b2.m_ack !== 2'b00 || b2.m_err !== 2'b00) begin
      miscompares++; $display("FAIL rmid_ackerr: got ack=%b err=%b want 00 00", b2.m_ack, b2.m_err); end
    rst = 1'b0; b2.s_ack = 1'b0; b2.m_stb = 2'b11;
    step(); @(negedge clk);
    vectors++; if (b2.s_stb !== 1'b1 || b2.s_adr !== 30'h100) begin
      miscompares++; $display("FAIL rmid_regrant: got stb=%b adr=%h want 1 100", b2.s_stb, b2.s_adr); end
    b2.m_stb = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_alternate();
    test_fair4();
    test_timeout();
    test_tmo_ack();
    test_abort();
    test_reset_mid();
    idle_inputs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/t5_wbarb.md
Name: t5_wbarb

Overview:
- Parametrised N-master to 1-slave Wishbone arbiter.
- Lets several t5 instruction/data ports (one or more cores) share a single memory bus.
- Generalises the fixed two-port (iwb/dwb) attachment of a single core to NM masters with round-robin fairness, a registered grant, abort handling and a bus-timeout error.
- Sits between the core bus ports and the memory/peripheral fabric.

Parameters:
- XLEN, 32, data width; byte-select width SW = XLEN/8.
- NM, 2, number of masters, 2..8.
- TMO, 255, max cycles granted without ack before error; 0 disables the timeout.

Ports:
- sys_clk  in  1  clock, rising edge.
- sys_rst  in  1  reset, asynchronous, active-high.
- m_adr  in  NM*30  master word addresses [31:2]; master i at [i*30 +: 30].
- m_dto  in  NM*XLEN  master write data.
- m_sel  in  NM*SW  master byte selects.
- m_wre  in  NM  master write enable.
- m_stb  in  NM  master strobe/request.
- m_ack  out  NM  per-master acknowledge.
- m_err  out  NM  per-master timeout error (one-cycle pulse).
- m_dti  out  XLEN  read data, broadcast to all masters.
- s_adr  out  30  slave word address.
- s_dto  out  XLEN  slave write data.
- s_sel  out  SW  slave byte selects.
- s_wre  out  1  slave write enable.
- s_stb  out  1  slave strobe.
- s_ack  in  1  slave acknowledge.
- s_dti  in  XLEN  slave read data.

Behaviour:
- State machine: IDLE, GRANT.
- Registers: gnt (one-hot NM), ptr (log2 NM, next-highest-priority master), tcnt (8-bit timeout counter).

Reset (sys_rst high, any time):
- State IDLE, gnt = 0, ptr = 0, tcnt = 0.
- s_stb = 0, s_wre = 0, s_sel = 0, s_adr = 0, s_dto = 0.
- m_ack = 0, m_err = 0.
- m_dti = s_dti at all times; it is not registered.
- Reset asserted mid-transaction drops s_stb asynchronously. No ack or err is delivered to the pending master.

IDLE:
- If any m_stb is set, pick the first requester at or after ptr, searching upward with wrap-around from NM-1 to 0.
- Register the winner into gnt, go to GRANT, clear tcnt.
- No request: stay in IDLE.

GRANT:
- s_adr/s_dto/s_sel/s_wre are muxed combinationally from the granted master.
- s_stb = m_stb[granted].
- Arbitration latency: request seen at edge N, s_stb high from cycle N+1.

Acknowledge:
- m_ack[g] = s_ack & s_stb, combinational pass-through. All other m_ack bits are 0.
- On the edge where s_ack & s_stb is sampled: go to IDLE, gnt = 0, ptr = (g+1) mod NM.
- Exactly one bubble cycle follows before the next grant.

Back-to-back and fairness:
- A master holding m_stb high across its ack re-enters arbitration at lower priority than every other current requester.
- A lone master is re-granted after the bubble, giving a throughput of 1 transfer per 2 cycles minimum.

Abort:
- If m_stb[g] drops while in GRANT without ack, return to IDLE next edge and set ptr = (g+1) mod NM.
- An s_ack arriving in the same cycle as the drop is ignored: s_stb is 0, so m_ack stays 0.

Timeout (TMO != 0):
- tcnt increments each GRANT cycle without ack.
- When tcnt == TMO-1 and there is no ack that cycle:
  - m_err[g] pulses high for the next single cycle (registered).
  - Go to IDLE, advance ptr.
- If ack and the timeout threshold coincide, ack wins and no err is raised.

Other rules:
- s_ack while in IDLE is ignored; no m_ack is generated.
- Grant changes only in IDLE; a higher-priority request never preempts a transfer in progress.

Test Plan:
- NM=2: master 0 read, adr 0x100, s_ack one cycle after s_stb, s_dti 0xDEADBEEF -> s_stb high 1 cycle after m_stb; m_ack[0] pulses with m_dti = 0xDEADBEEF; ptr = 1.
- NM=2: both masters request at cycle 0, each ack immediate -> grant order 0, 1, 0, 1. s_adr alternates between the two addresses; one idle cycle between grants.
- NM=4: masters 1 and 3 continuously requesting, ptr = 2 -> grant order 3, 1, 3, 1; masters 0 and 2 never granted and no m_ack to them.
- TMO=4: master 1 write, s_ack held low -> s_stb high 4 cycles; m_err[1] pulses on cycle 5; m_ack stays 0; next grant goes to master 0 if it is requesting.
- Abort: master 0 drops m_stb on the 2nd granted cycle while s_ack = 1 that cycle -> m_ack[0] = 0; s_stb low next cycle; state IDLE.
- Reset mid-transaction: sys_rst pulsed asynchronously between edges while s_stb = 1 -> s_stb, gnt, m_ack, m_err are 0 immediately; after release, the first grant goes to the lowest-indexed requester (ptr = 0).
